// File: rtl/sched_pkg.sv
// Shared sizes, FSM state type and slot arithmetic for the axon spike scheduler.
package sched_pkg;

  localparam int NUM_AXONS = 256;
  localparam int AXON_W    = 8;
  localparam int NUM_SLOTS = 16;
  localparam int DELAY_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2,
    CLEAR   = 2'd3
  } state_e;

  // NUM_SLOTS is a power of two, so truncation to DELAY_W bits is the modulo.
  function automatic logic [DELAY_W-1:0] slot_add(input logic [DELAY_W-1:0] ptr,
                                                   input logic [DELAY_W-1:0] delay);
    return ptr + delay;
  endfunction

endpackage

// File: rtl/sched_row_buffer.sv
// Circular buffer of per-tick axon activity rows: bit-set write, full-row read and clear.
// With SCHED_STATS_EN defined it also reports whether the bit being set was already 1.
module sched_row_buffer
  import sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en_i,
  input  logic [DELAY_W-1:0]   set_slot_i,
  input  logic [AXON_W-1:0]    set_axon_i,
  input  logic                 clr_en_i,
  input  logic [DELAY_W-1:0]   clr_slot_i,
  input  logic [DELAY_W-1:0]   rd_slot_i,
  output logic [NUM_AXONS-1:0] rd_row_o
`ifdef SCHED_STATS_EN
  ,
  output logic                 set_hit_o
`endif
);

  logic [NUM_AXONS-1:0] rows_q [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) rows_q[s] <= '0;
    end else begin
      if (set_en_i) rows_q[set_slot_i][set_axon_i] <= 1'b1;
      if (clr_en_i) rows_q[clr_slot_i] <= '0;
    end
  end

  assign rd_row_o = rows_q[rd_slot_i];

`ifdef SCHED_STATS_EN
  assign set_hit_o = rows_q[set_slot_i][set_axon_i];
`endif

endmodule

// File: rtl/axon_spike_scheduler.sv
// Per-core spike scheduler: stores delayed spikes per tick slot and serves the token controller.
// Optional SCHED_STATS_EN adds saturating accepted/duplicate/dropped spike counters.
module axon_spike_scheduler
  import sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  input  logic [AXON_W-1:0]    spike_axon,
  input  logic [DELAY_W-1:0]   spike_delay,
  input  logic                 scheduler_read_request,
  output logic [NUM_AXONS-1:0] axon_activity,
  output logic                 activity_valid,
  input  logic                 scheduler_clear_request,
  output logic [DELAY_W-1:0]   current_slot,
  output logic                 busy,
  output logic                 error,
  output logic                 err_illegal_delay,
  output logic                 err_tick_overrun
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]          spikes_accepted,
  output logic [15:0]          spikes_duplicate,
  output logic [15:0]          spikes_dropped
`endif
);

  state_e               state_q, state_d;
  logic [DELAY_W-1:0]   ptr_q;
  logic [NUM_AXONS-1:0] activity_q;
  logic                 err_ill_q, err_ovr_q;
  logic [NUM_AXONS-1:0] rd_row;
  logic                 spike_fire, spike_legal, spike_zero;
  logic [DELAY_W-1:0]   target_slot;

  assign spike_fire  = spike_valid && spike_ready;
  assign spike_zero  = spike_fire && (spike_delay == '0);
  assign spike_legal = spike_fire && (spike_delay != '0);
  // Uses the pre-tick pointer, so a delay-1 spike lands in the slot the tick moves to.
  assign target_slot = slot_add(ptr_q, spike_delay);

`ifdef SCHED_STATS_EN
  logic set_hit;
`endif

  sched_row_buffer u_rows (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (spike_legal),
    .set_slot_i (target_slot),
    .set_axon_i (spike_axon),
    .clr_en_i   (state_q == CLEAR),
    .clr_slot_i (ptr_q),
    .rd_slot_i  (ptr_q),
    .rd_row_o   (rd_row)
`ifdef SCHED_STATS_EN
    ,
    .set_hit_o  (set_hit)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scheduler_read_request) state_d = LOAD;
      LOAD:    state_d = PRESENT;
      PRESENT: if (scheduler_clear_request) state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spike_ready    = (state_q != CLEAR);
    busy           = (state_q != IDLE);
    activity_valid = (state_q == PRESENT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      activity_q <= '0;
      err_ill_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      if (tick && state_q == IDLE) ptr_q <= ptr_q + 1'b1;
      if (tick && state_q != IDLE) err_ovr_q <= 1'b1;
      if (spike_zero) err_ill_q <= 1'b1;
      if (state_q == LOAD)  activity_q <= rd_row;
      if (state_q == CLEAR) activity_q <= '0;
    end
  end

  assign axon_activity     = activity_q;
  assign current_slot      = ptr_q;
  assign err_illegal_delay = err_ill_q;
  assign err_tick_overrun  = err_ovr_q;
  assign error             = err_ill_q | err_ovr_q;

`ifdef SCHED_STATS_EN
  logic [15:0] acc_q, dup_q, drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      dup_q  <= '0;
      drop_q <= '0;
    end else begin
      if (spike_legal && acc_q != 16'hFFFF)            acc_q  <= acc_q + 16'd1;
      if (spike_legal && set_hit && dup_q != 16'hFFFF) dup_q  <= dup_q + 16'd1;
      if (spike_zero && drop_q != 16'hFFFF)            drop_q <= drop_q + 16'd1;
    end
  end

  assign spikes_accepted  = acc_q;
  assign spikes_duplicate = dup_q;
  assign spikes_dropped   = drop_q;
`endif

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Directed bench for axon_spike_scheduler: spike scheduling, wrap-around, error flags, reset mid-read.
module tb_axon_spike_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         spike_valid;
  logic         spike_ready;
  logic [7:0]   spike_axon;
  logic [3:0]   spike_delay;
  logic         scheduler_read_request;
  logic [255:0] axon_activity;
  logic         activity_valid;
  logic         scheduler_clear_request;
  logic [3:0]   current_slot;
  logic         busy;
  logic         error;
  logic         err_illegal_delay;
  logic         err_tick_overrun;
`ifdef SCHED_STATS_EN
  logic [15:0]  spikes_accepted, spikes_duplicate, spikes_dropped;
`endif

  int checks = 0;
  int errors = 0;

  axon_spike_scheduler dut (
    .clk                     (clk),
    .rst                     (rst),
    .tick                    (tick),
    .spike_valid             (spike_valid),
    .spike_ready             (spike_ready),
    .spike_axon              (spike_axon),
    .spike_delay             (spike_delay),
    .scheduler_read_request  (scheduler_read_request),
    .axon_activity           (axon_activity),
    .activity_valid          (activity_valid),
    .scheduler_clear_request (scheduler_clear_request),
    .current_slot            (current_slot),
    .busy                    (busy),
    .error                   (error),
    .err_illegal_delay       (err_illegal_delay),
    .err_tick_overrun        (err_tick_overrun)
`ifdef SCHED_STATS_EN
    ,
    .spikes_accepted         (spikes_accepted),
    .spikes_duplicate        (spikes_duplicate),
    .spikes_dropped          (spikes_dropped)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] bit_of(input int a);
    logic [255:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic spike(input int axon, input int delay, input logic with_tick);
    spike_valid = 1'b1;
    spike_axon  = axon[7:0];
    spike_delay = delay[3:0];
    tick        = with_tick;
    #0;
    chk("spike_ready", spike_ready, 1);
    cyc();
    spike_valid = 1'b0;
    tick        = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [255:0] exp, input logic with_tick);
    scheduler_read_request = 1'b1;
    tick = with_tick;
    cyc();
    scheduler_read_request = 1'b0;
    tick = 1'b0;
    chk({tag, "_load_valid"}, activity_valid, 0);
    chk({tag, "_load_busy"}, busy, 1);
    cyc();
    chk({tag, "_valid"}, activity_valid, 1);
    chk({tag, "_row"}, axon_activity, exp);
    scheduler_read_request = 1'b1;
    cyc();
    scheduler_read_request = 1'b0;
    chk({tag, "_hold_valid"}, activity_valid, 1);
    chk({tag, "_hold_row"}, axon_activity, exp);
    scheduler_clear_request = 1'b1;
    cyc();
    scheduler_clear_request = 1'b0;
    chk({tag, "_clear_ready"}, spike_ready, 0);
    chk({tag, "_clear_valid"}, activity_valid, 0);
    cyc();
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_row"}, axon_activity, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, spike_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, activity_valid, 0);
    chk({tag, "_row"}, axon_activity, 0);
    chk({tag, "_slot"}, current_slot, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_err_ill"}, err_illegal_delay, 0);
    chk({tag, "_err_ovr"}, err_tick_overrun, 0);
  endtask

  initial begin
    logic [255:0] e;
    rst = 1'b0; tick = 1'b0; spike_valid = 1'b0; spike_axon = '0; spike_delay = '0;
    scheduler_read_request = 1'b0; scheduler_clear_request = 1'b0;

    do_reset();
    chk_reset_state("reset");

    // Test 1: two delay-1 spikes, one tick, read returns bits 5 and 10.
    spike(5, 1, 1'b0);
    spike(10, 1, 1'b0);
    scheduler_clear_request = 1'b1;
    cyc();
    scheduler_clear_request = 1'b0;
    chk("idle_clear_ignored", busy, 0);
    do_tick();
    chk("t1_slot", current_slot, 1);
    e = bit_of(5) | bit_of(10);
    do_read("t1", e, 1'b0);

    // Test 2: delay-3 spike appears only on the third tick.
    do_reset();
    spike(200, 3, 1'b0);
    do_tick();
    do_read("t2_tick1", '0, 1'b0);
    do_tick();
    do_read("t2_tick2", '0, 1'b0);
    do_tick();
    chk("t2_slot", current_slot, 3);
    do_read("t2_tick3", bit_of(200), 1'b0);

    // Test 3: wrap-around from slot 15.
    do_reset();
    for (int i = 0; i < 15; i++) do_tick();
    chk("t3_slot15", current_slot, 15);
    spike(7, 2, 1'b0);
    do_tick();
    chk("t3_wrap0", current_slot, 0);
    do_tick();
    chk("t3_slot1", current_slot, 1);
    do_read("t3", bit_of(7), 1'b0);

    // Test 4: delay-0 spike is consumed, flagged, and written nowhere.
    spike(9, 0, 1'b0);
    chk("t4_err_ill", err_illegal_delay, 1);
    chk("t4_error", error, 1);
    chk("t4_err_ovr", err_tick_overrun, 0);
    for (int i = 0; i < 16; i++) begin
      do_tick();
      do_read($sformatf("t4_slot%0d", i), '0, 1'b0);
    end
    chk("t4_slot_back", current_slot, 1);

    // Test 5: tick during PRESENT is ignored and flagged.
    scheduler_read_request = 1'b1;
    cyc();
    scheduler_read_request = 1'b0;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("t5_slot_held", current_slot, 1);
    chk("t5_err_ovr", err_tick_overrun, 1);
    chk("t5_still_valid", activity_valid, 1);
    scheduler_clear_request = 1'b1;
    cyc();
    scheduler_clear_request = 1'b0;
    cyc();
    chk("t5_idle", busy, 0);
    // spike with delay 1 in the same cycle as a tick lands in the new current slot
    spike(33, 1, 1'b1);
    chk("t5_tick_slot", current_slot, 2);
    do_read("t5_same_cycle", bit_of(33), 1'b0);
    // read_request together with tick reads the advanced slot
    spike(44, 1, 1'b0);
    do_read("t5_read_tick", bit_of(44), 1'b1);
    chk("t5_read_tick_slot", current_slot, 3);
    chk("t5_sticky_ill", err_illegal_delay, 1);

    // Test 6: reset during PRESENT discards everything.
    spike(100, 2, 1'b0);
    spike(101, 1, 1'b0);
    do_tick();
    scheduler_read_request = 1'b1;
    cyc();
    scheduler_read_request = 1'b0;
    cyc();
    chk("t6_present_row", axon_activity, bit_of(101));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_reset_state("t6_rst");
    do_tick();
    do_read("t6_after", '0, 1'b0);
    for (int i = 0; i < 4; i++) do_tick();
    chk("t6_slot5", current_slot, 5);
    do_read("t6_slot5", '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axon_spike_scheduler.md
Name: axon_spike_scheduler

Overview:
- Per-core spike scheduler and the responder on the scheduler side of the token controller interface.
- Accepts incoming spike events of {axon, delay}, coming from the router or the core's own spike loopback.
- Stores them in a circular buffer of per-tick axon activity rows.
- On each tick, presents the due row as axon_activity when the token controller sends scheduler_read_request, and zeroes that row on scheduler_clear_request.

Parameters:
NUM_AXONS, 256, axons per core; width of one activity row
AXON_W, 8, axon index width (log2 NUM_AXONS)
NUM_SLOTS, 16, delay slots in the circular buffer
DELAY_W, 4, delay field and slot pointer width (log2 NUM_SLOTS)

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
tick  in  1  one-cycle global tick pulse
spike_valid  in  1  incoming spike event valid
spike_ready  out  1  scheduler can accept the event this cycle
spike_axon  in  AXON_W  target axon index
spike_delay  in  DELAY_W  delivery delay in ticks; legal range 1..NUM_SLOTS-1
scheduler_read_request  in  1  token controller requests the current row
axon_activity  out  NUM_AXONS  row for the current slot; valid while activity_valid is high
activity_valid  out  1  axon_activity is stable and valid
scheduler_clear_request  in  1  token controller finished; clear the current row
current_slot  out  DELAY_W  slot pointer for the current tick
busy  out  1  state is not IDLE
error  out  1  sticky error; OR of err_illegal_delay and err_tick_overrun
err_illegal_delay  out  1  sticky; a spike arrived with delay 0
err_tick_overrun  out  1  sticky; a tick arrived while state is not IDLE

Behaviour:
- Storage: NUM_SLOTS x NUM_AXONS flop array `rows`; pointer `ptr`.
- Reset (synchronous, checked first, overrides everything):
  - All rows = 0, ptr = 0, state = IDLE.
  - All outputs 0 except spike_ready = 1.
  - All sticky flags cleared.
  - Reset mid-read discards the outstanding handshake and all stored spikes.
- Spike accept: handshake completes when spike_valid && spike_ready.
  - spike_ready = 1 in every state except CLEAR.
  - Target slot = (ptr + spike_delay) mod NUM_SLOTS, using the pre-update ptr of that cycle.
  - Action: rows[target][spike_axon] <= 1. Duplicate events are idempotent.
- Delay 0: the event is consumed (handshake completes), not written, and err_illegal_delay is set.
  - Consequence: the target slot never equals ptr, so writes never collide with the row being read.
- Tick: in IDLE, ptr <= ptr + 1, wrapping 15 -> 0. A spike accepted in the same cycle uses the old ptr, so a delay-1 spike lands in the new current slot.
- Tick when state is not IDLE: ignored (ptr holds) and err_tick_overrun is set.
- FSM:
  - IDLE: read_request -> LOAD.
  - LOAD (1 cycle): axon_activity <= rows[ptr] -> PRESENT.
  - PRESENT: activity_valid = 1, axon_activity held stable. clear_request -> CLEAR. read_request is ignored here.
  - CLEAR (1 cycle): rows[ptr] <= 0, activity_valid <= 0, axon_activity <= 0 -> IDLE.
- Read latency: request in cycle N -> activity_valid high in cycle N+2.
- clear_request in IDLE or LOAD: ignored (no-op).
- read_request and tick together in IDLE: tick advances ptr first, then LOAD reads the new slot in the next cycle.
- Sticky flags clear only on rst.

Optional Feature:
- Macro: SCHED_STATS_EN.
- Defined: adds output ports
  - spikes_accepted [15:0]: legal writes.
  - spikes_duplicate [15:0]: legal writes whose target bit was already 1.
  - spikes_dropped [15:0]: delay-0 events.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package sched_pkg holds:
  - NUM_AXONS, NUM_SLOTS, AXON_W, DELAY_W.
  - State enum {IDLE, LOAD, PRESENT, CLEAR}.
  - Function slot_add(ptr, delay) for modulo slot addition.
- One sub-module, sched_row_buffer: the flop array with a one-hot bit-set write port, a full-row read port and a full-row clear port. The FSM and handshakes stay in the top.

Test Plan:
1. Reset, then spikes {axon 5, delay 1} and {axon 10, delay 1}, then tick, then read_request → after 2 cycles activity_valid=1 and axon_activity has only bits 5 and 10 set. clear_request → row zeroed and busy=0 one cycle later.
2. Spike {axon 200, delay 3} → no activity on ticks 1 and 2. On tick 3 the read returns only bit 200; current_slot = 3.
3. Wrap-around: 15 ticks (ptr = 15), then {axon 7, delay 2}, then 2 ticks → ptr = 1 and the read returns bit 7.
4. Spike {axon 9, delay 0} → spike_ready handshake completes, err_illegal_delay=1, error=1, and no row contains bit 9.
5. Tick asserted while in PRESENT → ptr unchanged, err_tick_overrun=1. Spike accepted in the same cycle as a tick with delay 1 → appears on the read after that tick.
6. rst asserted during PRESENT with stored spikes → next cycle all outputs 0, spike_ready=1. After one tick, a subsequent read returns all zeros.
